// File: rtl/full_sum_pkg.sv
// Shared definitions for the serial multi-operand adder full_sum_seq:
// the frame state encoding and a constant clog2 helper for sizing counters.
package full_sum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest number of bits w such that 2**w >= value.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/full_sum_seq_if.sv
// Operand-in / sum-out stream bundle for full_sum_seq.
// master = producer/consumer side, slave = the adder itself.
interface full_sum_seq_if #(
    parameter int input_width  = 32,
    parameter int output_width = 32
);
    logic                    CLR;
    logic                    IN_VALID;
    logic                    IN_READY;
    logic [input_width-1:0]  IN_DATA;
    logic                    OUT_VALID;
    logic                    OUT_READY;
    logic [output_width-1:0] SUM;
    logic                    SAT_FLAG;

    modport master (
        output CLR, IN_VALID, IN_DATA, OUT_READY,
        input  IN_READY, OUT_VALID, SUM, SAT_FLAG
    );

    modport slave (
        input  CLR, IN_VALID, IN_DATA, OUT_READY,
        output IN_READY, OUT_VALID, SUM, SAT_FLAG
    );
endinterface

// File: rtl/full_sum_acc.sv
// Registered accumulate step for full_sum_seq.
// Operands are zero-extended or truncated to output_width before adding.
// FULL_SUM_SEQ_SAT_EN: additions clamp at all-ones and a sticky sat bit
// records that the current frame clamped; otherwise additions wrap.
// acc_o/sat_o present the value the accumulator takes at the coming edge,
// so the owner can capture a finished frame without an extra cycle.
module full_sum_acc #(
    parameter int input_width  = 32,
    parameter int output_width = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic                    load_i,
    input  logic                    add_i,
    input  logic [input_width-1:0]  operand_i,
    output logic [output_width-1:0] acc_o,
    output logic                    sat_o
);

    logic [output_width-1:0] acc_q;
    logic [output_width-1:0] acc_d;
    logic [output_width-1:0] opExt;
    logic                    sat_q;
    logic                    sat_d;
`ifdef FULL_SUM_SEQ_SAT_EN
    logic [output_width:0]   sumWide;
`endif

    // Next accumulator value: flush, start a frame, or add one operand.
    always_comb begin
        opExt = output_width'(operand_i);
        acc_d = acc_q;
        sat_d = sat_q;
`ifdef FULL_SUM_SEQ_SAT_EN
        sumWide = {1'b0, acc_q} + {1'b0, opExt};
`endif
        if (clr_i) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (load_i) begin
            acc_d = opExt;
            sat_d = 1'b0;
        end else if (add_i) begin
`ifdef FULL_SUM_SEQ_SAT_EN
            if (sumWide[output_width]) begin
                acc_d = '1;
                sat_d = 1'b1;
            end else begin
                acc_d = sumWide[output_width-1:0];
            end
`else
            acc_d = acc_q + opExt;
`endif
        end
    end

    // Running-sum storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    assign acc_o = acc_d;
    assign sat_o = sat_d;

endmodule

// File: rtl/full_sum_seq.sv
// Serial multi-operand adder: takes num_inputs operands one per beat and
// presents their sum on a valid/ready output, bit-identical to full_sum.
// FULL_SUM_SEQ_SAT_EN enables per-step saturation and SAT_FLAG; without it
// the sum wraps and SAT_FLAG stays 0.
module full_sum_seq
    import full_sum_pkg::*;
#(
    parameter int num_inputs   = 4,
    parameter int input_width  = 32,
    parameter int output_width = 32
) (
    input logic           CLK,
    input logic           RST,
    full_sum_seq_if.slave bus
);

    localparam int             CW         = clog2(num_inputs + 1);
    localparam logic [CW-1:0]  LAST_COUNT = CW'(num_inputs - 1);
    localparam logic [CW-1:0]  ONE_COUNT  = CW'(1);

    state_t                  state_q;
    logic [CW-1:0]           count_q;
    logic [output_width-1:0] sum_q;
    logic                    outValid_q;
    logic                    satFlag_q;

    logic [output_width-1:0] accNext;
    logic                    satNext;
    logic                    inReady;
    logic                    inBeat;
    logic                    outBeat;
    logic                    lastBeat;
    logic                    loadAcc;
    logic                    addAcc;

    // Handshake decode; a held result blocks input unless it leaves this cycle.
    always_comb begin
        inReady  = (state_q != DONE) | bus.OUT_READY;
        inBeat   = bus.IN_VALID & inReady & ~bus.CLR;
        outBeat  = outValid_q & bus.OUT_READY;
        loadAcc  = inBeat & (state_q != ACC);
        addAcc   = inBeat & (state_q == ACC);
        lastBeat = (state_q == ACC) ? (count_q == LAST_COUNT) : (num_inputs == 1);
    end

    full_sum_acc #(
        .input_width (input_width),
        .output_width(output_width)
    ) u_acc (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clr_i    (bus.CLR),
        .load_i   (loadAcc),
        .add_i    (addAcc),
        .operand_i(bus.IN_DATA),
        .acc_o    (accNext),
        .sat_o    (satNext)
    );

    // Frame FSM with operand counter and registered result outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            count_q    <= '0;
            sum_q      <= '0;
            outValid_q <= 1'b0;
            satFlag_q  <= 1'b0;
        end else if (bus.CLR) begin
            state_q    <= IDLE;
            count_q    <= '0;
            sum_q      <= '0;
            outValid_q <= 1'b0;
            satFlag_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (inBeat) begin
                        count_q <= ONE_COUNT;
                        if (lastBeat) begin
                            state_q    <= DONE;
                            outValid_q <= 1'b1;
                            sum_q      <= accNext;
                            satFlag_q  <= satNext;
                        end else begin
                            state_q    <= ACC;
                            outValid_q <= 1'b0;
                        end
                    end else if (outBeat) begin
                        state_q    <= IDLE;
                        count_q    <= '0;
                        outValid_q <= 1'b0;
                    end
                end
                ACC: begin
                    if (inBeat) begin
                        count_q <= count_q + ONE_COUNT;
                        if (lastBeat) begin
                            state_q    <= DONE;
                            outValid_q <= 1'b1;
                            sum_q      <= accNext;
                            satFlag_q  <= satNext;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    count_q    <= '0;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.IN_READY  = inReady;
    assign bus.OUT_VALID = outValid_q;
    assign bus.SUM       = sum_q;
    assign bus.SAT_FLAG  = satFlag_q;

endmodule

// File: tb/tb_full_sum_seq.sv
// Bench for full_sum_seq: a default 4x32->32 instance tracked every cycle
// against a queue-based frame model, plus an 8->4 bit instance for
// truncation and wrap. Expectations follow FULL_SUM_SEQ_SAT_EN when defined.
module tb_full_sum_seq;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   testsRun    = 0;
    int   testsFailed = 0;

    full_sum_seq_if #(.input_width(32), .output_width(32)) bus ();
    full_sum_seq_if #(.input_width(8),  .output_width(4))  nbus ();

    full_sum_seq #(.num_inputs(4), .input_width(32), .output_width(32)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    full_sum_seq #(.num_inputs(4), .input_width(8), .output_width(4)) ndut (
        .CLK(CLK),
        .RST(RST),
        .bus(nbus)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [31:0] d);
        logic [31:0] ops [4];
        ops = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            bus.IN_VALID = 1'b1;
            bus.IN_DATA  = ops[i];
            tick();
        end
        bus.IN_VALID = 1'b0;
    endtask

    task automatic applyNarrow(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d);
        logic [7:0] ops [4];
        ops = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            nbus.IN_VALID = 1'b1;
            nbus.IN_DATA  = ops[i];
            tick();
        end
        nbus.IN_VALID = 1'b0;
    endtask

    // Frame model: collect accepted operands, sum a full frame arithmetically.
    logic [31:0]     part [$];
    logic            expValid = 1'b0;
    logic [31:0]     expSum   = '0;
    logic            expSat   = 1'b0;
    longint unsigned total;
    logic            sawSat;
    logic            takeIn;
    logic            takeOut;

    always @(posedge CLK or posedge RST) begin
        if (RST || bus.CLR) begin
            part.delete();
            expValid = 1'b0;
            expSum   = '0;
            expSat   = 1'b0;
        end else begin
            takeOut = expValid && bus.OUT_READY;
            takeIn  = bus.IN_VALID && (!expValid || bus.OUT_READY);
            if (takeOut) expValid = 1'b0;
            if (takeIn) begin
                part.push_back(bus.IN_DATA);
                if (part.size() == 4) begin
                    total  = 0;
                    sawSat = 1'b0;
                    foreach (part[k]) begin
                        total = total + part[k];
`ifdef FULL_SUM_SEQ_SAT_EN
                        if (total > 64'hFFFF_FFFF) begin
                            total  = 64'hFFFF_FFFF;
                            sawSat = 1'b1;
                        end
`endif
                    end
                    expSum   = total[31:0];
                    expSat   = sawSat;
                    expValid = 1'b1;
                    part.delete();
                end
            end
        end
    end

    // Every-cycle comparison of the default instance against the model.
    always @(negedge CLK) begin
        if (!RST) begin
            checkOutput("model_in_ready", bus.IN_READY, (!expValid) || bus.OUT_READY);
            checkOutput("model_out_valid", bus.OUT_VALID, expValid);
            checkOutput("model_sum", bus.SUM, expSum);
            checkOutput("model_sat", bus.SAT_FLAG, expSat);
        end
    end

    initial begin
        int validSeen;
        bus.CLR = 1'b0;  bus.IN_VALID = 1'b0;  bus.IN_DATA = '0;  bus.OUT_READY = 1'b1;
        nbus.CLR = 1'b0; nbus.IN_VALID = 1'b0; nbus.IN_DATA = '0; nbus.OUT_READY = 1'b1;

        #1;
        checkOutput("reset_in_ready", bus.IN_READY, 1'b1);
        checkOutput("reset_out_valid", bus.OUT_VALID, 1'b0);
        checkOutput("reset_sum", bus.SUM, 32'h0);
        checkOutput("reset_sat", bus.SAT_FLAG, 1'b0);
        checkOutput("reset_narrow_sum", nbus.SUM, 4'h0);
        #12 RST = 1'b0;
        tick();

        // Basic frame 1,2,3,4.
        applyStimulus(32'd1, 32'd2, 32'd3, 32'd4);
        checkOutput("basic_valid", bus.OUT_VALID, 1'b1);
        checkOutput("basic_sum", bus.SUM, 32'd10);
        tick();
        checkOutput("basic_idle", bus.OUT_VALID, 1'b0);
        checkOutput("basic_sum_held", bus.SUM, 32'd10);

        // Overflow: wrap or saturate.
        applyStimulus(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        checkOutput("ovf_valid", bus.OUT_VALID, 1'b1);
`ifdef FULL_SUM_SEQ_SAT_EN
        checkOutput("ovf_sum", bus.SUM, 32'hFFFF_FFFF);
        checkOutput("ovf_sat", bus.SAT_FLAG, 1'b1);
`else
        checkOutput("ovf_sum", bus.SUM, 32'h0);
        checkOutput("ovf_sat", bus.SAT_FLAG, 1'b0);
`endif
        tick();

        // Backpressure: result held while OUT_READY is low.
        bus.OUT_READY = 1'b0;
        applyStimulus(32'd5, 32'd5, 32'd5, 32'd5);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_valid", bus.OUT_VALID, 1'b1);
            checkOutput("bp_sum", bus.SUM, 32'd20);
            checkOutput("bp_in_ready", bus.IN_READY, 1'b0);
            if (i < 2) tick();
        end
        bus.OUT_READY = 1'b1;
        #1;
        checkOutput("bp_release_ready", bus.IN_READY, 1'b1);
        tick();
        checkOutput("bp_drained", bus.OUT_VALID, 1'b0);
        checkOutput("bp_sat_clear", bus.SAT_FLAG, 1'b0);

        // Zero-bubble turnover: two frames back to back.
        bus.IN_VALID = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.IN_DATA = (i <= 4) ? 32'd1 : 32'd2;
            tick();
            checkOutput("zb_in_ready", bus.IN_READY, 1'b1);
            if (i == 4) checkOutput("zb_first_sum", bus.SUM, 32'd4);
            if (i == 4 || i == 8) checkOutput("zb_valid", bus.OUT_VALID, 1'b1);
            if (i == 5) checkOutput("zb_gap", bus.OUT_VALID, 1'b0);
        end
        checkOutput("zb_second_sum", bus.SUM, 32'd8);
        bus.IN_VALID = 1'b0;
        tick();

        // CLR mid-frame drops the coincident operand.
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 32'd7;
        tick();
        tick();
        bus.CLR     = 1'b1;
        bus.IN_DATA = 32'd9;
        tick();
        bus.CLR      = 1'b0;
        bus.IN_VALID = 1'b0;
        checkOutput("clr_valid", bus.OUT_VALID, 1'b0);
        checkOutput("clr_sum", bus.SUM, 32'd0);
        applyStimulus(32'd5, 32'd5, 32'd5, 32'd5);
        validSeen = 0;
        if (bus.OUT_VALID) validSeen++;
        checkOutput("clr_frame_sum", bus.SUM, 32'd20);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.OUT_VALID) validSeen++;
        end
        checkOutput("clr_single_result", validSeen, 1);

        // Asynchronous reset between edges after two beats.
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 32'd6;
        tick();
        tick();
        bus.IN_VALID = 1'b0;
        #2 RST = 1'b1;
        #1;
        checkOutput("arst_sum", bus.SUM, 32'd0);
        checkOutput("arst_valid", bus.OUT_VALID, 1'b0);
        checkOutput("arst_in_ready", bus.IN_READY, 1'b1);
        #3 RST = 1'b0;
        applyStimulus(32'd3, 32'd3, 32'd3, 32'd3);
        checkOutput("arst_next_valid", bus.OUT_VALID, 1'b1);
        checkOutput("arst_next_sum", bus.SUM, 32'd12);
        tick();

        // Narrow instance: 8-bit operands into a 4-bit sum.
        applyNarrow(8'h0F, 8'h01, 8'h00, 8'h00);
        checkOutput("narrow_valid", nbus.OUT_VALID, 1'b1);
`ifdef FULL_SUM_SEQ_SAT_EN
        checkOutput("narrow_sum", nbus.SUM, 4'hF);
        checkOutput("narrow_sat", nbus.SAT_FLAG, 1'b1);
`else
        checkOutput("narrow_sum", nbus.SUM, 4'h0);
        checkOutput("narrow_sat", nbus.SAT_FLAG, 1'b0);
`endif
        tick();
        applyNarrow(8'h13, 8'h02, 8'h00, 8'h00);
        checkOutput("narrow_trunc_sum", nbus.SUM, 4'h5);
        checkOutput("narrow_trunc_sat", nbus.SAT_FLAG, 1'b0);
        tick();
        checkOutput("narrow_idle", nbus.OUT_VALID, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
